craft_mc_ctrl: RTL

//  Sequencer for the nibble-serial CRAFT MixColumns datapath (4 x 4-bit shift/XOR registers).
//  - Streams NUM_COLS columns in, generates CM0/CM1 each cycle, and streams the results out.
//  - Uses valid/ready handshakes on both sides. Data nibbles go straight to the datapath;

---
 rtl/craft_mc_if.sv | 29 ++
 rtl/craft_mc_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/craft_mc_if.sv
// Handshake bundle between the CRAFT MixColumns sequencer and its stream
// neighbours. The upstream side offers nibbles (s_valid/s_ready). The
// downstream side takes results (m_valid/m_ready) and gets m_last on the
// final nibble of a block.
interface craft_mc_if;
    logic s_valid;
    logic s_ready;
    logic m_valid;
    logic m_ready;
    logic m_last;

    // Environment side: offers input nibbles and accepts output nibbles
    modport master (
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_last
    );

    // Sequencer side: answers the input handshake and qualifies the output
    modport slave (
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_last
    );
endinterface

// File: rtl/craft_mc_ctrl.sv
// Sequencer for the nibble-serial CRAFT MixColumns datapath.
// Each column is shifted in over 4 accepted nibbles, mixed in one COMP cycle,
// and shifted out while the next column shifts in. After the last column a
// FLUSH phase drains the final four results. cm0/cm1/s_ready/m_valid are
// combinational so the datapath acts on them in the same cycle.
module craft_mc_ctrl #(
    parameter int NUM_COLS = 4,
    parameter int CNT_W    = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    craft_mc_if.slave bus,
    output logic      cm0,
    output logic      cm1,
    output logic      busy,
    output logic      done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COMP  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

    state_t           state_reg, state_next;
    logic [1:0]       nib_reg, nib_next;
    logic [CNT_W-1:0] col_reg, col_next;
    logic             done_reg, done_next;

    logic drain;
    logic fire;
    logic shift;
    logic comp;
    logic s_ready_c;
    logic m_valid_c;
    logic m_last_c;

    // busy still covers the done cycle, so a start on that cycle is ignored
    assign busy = (state_reg != IDLE) || done_reg;
    assign done = done_reg;

    // cm0=1,cm1=0 cannot occur: cm0 is only ever the shift request
    assign cm0 = shift;
    assign cm1 = shift | comp;

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_c;
    assign bus.m_last  = m_last_c;

    // Next-state, counters and combinational handshake/datapath controls
    always_comb begin
        state_next = state_reg;
        nib_next   = nib_reg;
        col_next   = col_reg;
        done_next  = 1'b0;
        drain      = 1'b0;
        fire       = 1'b0;
        shift      = 1'b0;
        comp       = 1'b0;
        s_ready_c  = 1'b0;
        m_valid_c  = 1'b0;
        m_last_c   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start && !busy) begin
                    state_next = LOAD;
                    nib_next   = 2'd0;
                    col_next   = '0;
                end
            end

            LOAD: begin
                // From the second column on, r3 holds a finished result, so an
                // input shift is only allowed when downstream takes that result.
                drain     = (col_reg != '0);
                fire      = bus.s_valid && (bus.m_ready || !drain);
                s_ready_c = !drain || bus.m_ready;
                m_valid_c = drain && bus.s_valid;
                shift     = fire;
                if (fire) begin
                    nib_next = nib_reg + 2'd1;
                    if (nib_reg == 2'd3) begin
                        state_next = COMP;
                    end
                end
            end

            COMP: begin
                // One unconditional mixing cycle; nothing moves on either port
                comp     = 1'b1;
                nib_next = 2'd0;
                if (col_reg == LAST_COL) begin
                    state_next = FLUSH;
                end else begin
                    col_next   = col_reg + CNT_W'(1);
                    state_next = LOAD;
                end
            end

            FLUSH: begin
                m_valid_c = 1'b1;
                m_last_c  = (nib_reg == 2'd3);
                shift     = bus.m_ready;
                if (bus.m_ready) begin
                    nib_next = nib_reg + 2'd1;
                    if (nib_reg == 2'd3) begin
                        state_next = IDLE;
                        nib_next   = 2'd0;
                        col_next   = '0;
                        done_next  = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any partial block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            nib_reg   <= 2'd0;
            col_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            nib_reg   <= nib_next;
            col_reg   <= col_next;
            done_reg  <= done_next;
        end
    end
endmodule
